decode_execute_stage: RTL and testbench

- Pipeline stage between instruction decode and execute.
- Drives the register-file read addresses from the decode-stage instruction.
- Bypasses same-cycle write-back data over the register-file read data, then registers operands and control into the execute stage.
- Detects load-use hazards, inserts bubbles, honours downstream hold and branch flush, and counts stall cycles for performance monitoring.

---
 rtl/decode_execute_stage_if.sv | 53 +++++
 rtl/decode_execute_stage.sv | 126 ++++++++++++
 tb/tb_decode_execute_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/decode_execute_stage_if.sv
// Decode-to-execute stage bus: decode inputs, register-file read port,
// write-back bypass source, execute-stage outputs and stall reporting.
interface decode_execute_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
);
    logic              valid_d;
    logic [31:0]       instr_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc_plus4_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              reg_write_d;
    logic              mem_read_d;
    logic [4:0]        rs1_d;
    logic [4:0]        rs2_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              hold_e;
    logic              flush_e;
    logic              stall_d;
    logic              valid_e;
    logic              reg_write_e;
    logic              mem_read_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [XLEN-1:0]   pc_e;
    logic [XLEN-1:0]   pc_plus4_e;
    logic [XLEN-1:0]   op1_e;
    logic [XLEN-1:0]   op2_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  valid_d, instr_d, pc_d, pc_plus4_d, ctrl_d, reg_write_d, mem_read_d,
        input  rd1_d, rd2_d, wb_we, wb_rd, wb_data, hold_e, flush_e,
        output rs1_d, rs2_d, stall_d,
        output valid_e, reg_write_e, mem_read_e, ctrl_e, pc_e, pc_plus4_e,
        output op1_e, op2_e, rs1_e, rs2_e, rd_e, stall_cnt
    );

    modport master (
        output valid_d, instr_d, pc_d, pc_plus4_d, ctrl_d, reg_write_d, mem_read_d,
        output rd1_d, rd2_d, wb_we, wb_rd, wb_data, hold_e, flush_e,
        input  rs1_d, rs2_d, stall_d,
        input  valid_e, reg_write_e, mem_read_e, ctrl_e, pc_e, pc_plus4_e,
        input  op1_e, op2_e, rs1_e, rs2_e, rd_e, stall_cnt
    );
endinterface

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with write-back bypass, load-use bubble
// insertion, hold/flush handling and a saturating stall-cycle counter.
module decode_execute_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_execute_stage_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } ex_t;

    localparam ex_t            EX_CLEAR = ex_t'({$bits(ex_t){1'b0}});
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] op1_next_s;
    logic [XLEN-1:0] op2_next_s;
    logic            load_use_s;
    logic            stall_s;
    logic            unused_instr_s;
    ex_t             ex_load_s;
    ex_t             ex_r;
    logic [CNT_W-1:0] stall_cnt_r;

    assign rs1_s = bus.instr_d[19:15];
    assign rs2_s = bus.instr_d[24:20];
    assign rd_s  = bus.instr_d[11:7];
    assign unused_instr_s = ^{bus.instr_d[31:25], bus.instr_d[14:12], bus.instr_d[6:0]};

    // Same-cycle write-back overrides stale register-file data; x0 is never bypassed
    always_comb begin
        op1_next_s = bus.rd1_d;
        op2_next_s = bus.rd2_d;
        if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs1_s)) begin
            op1_next_s = bus.wb_data;
        end else begin
            op1_next_s = bus.rd1_d;
        end
        if (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs2_s)) begin
            op2_next_s = bus.wb_data;
        end else begin
            op2_next_s = bus.rd2_d;
        end
    end

    // A load in execute whose result the decode instruction needs cannot be forwarded yet
    assign load_use_s = bus.valid_d && ex_r.valid && ex_r.mem_read && (ex_r.rd != 5'd0) &&
                        ((ex_r.rd == rs1_s) || (ex_r.rd == rs2_s));
    assign stall_s    = bus.hold_e || load_use_s;

    // Assemble the execute-stage word loaded in the normal (no stall, no flush) case
    always_comb begin
        ex_load_s           = EX_CLEAR;
        ex_load_s.valid     = bus.valid_d;
        ex_load_s.reg_write = bus.reg_write_d;
        ex_load_s.mem_read  = bus.mem_read_d;
        ex_load_s.ctrl      = bus.ctrl_d;
        ex_load_s.pc        = bus.pc_d;
        ex_load_s.pc_plus4  = bus.pc_plus4_d;
        ex_load_s.op1       = op1_next_s;
        ex_load_s.op2       = op2_next_s;
        ex_load_s.rs1       = rs1_s;
        ex_load_s.rs2       = rs2_s;
        ex_load_s.rd        = rd_s;
    end

    // Execute register: flush outranks hold so a redirect is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r <= EX_CLEAR;
        end else if (bus.flush_e) begin
            ex_r <= EX_CLEAR;
        end else if (bus.hold_e) begin
            ex_r <= ex_r;
        end else if (load_use_s) begin
            ex_r <= EX_CLEAR;
        end else begin
            ex_r <= ex_load_s;
        end
    end

    // Saturating count of cycles in which upstream was told to stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.rs1_d       = rs1_s;
    assign bus.rs2_d       = rs2_s;
    assign bus.stall_d     = stall_s;
    assign bus.valid_e     = ex_r.valid;
    assign bus.reg_write_e = ex_r.reg_write;
    assign bus.mem_read_e  = ex_r.mem_read;
    assign bus.ctrl_e      = ex_r.ctrl;
    assign bus.pc_e        = ex_r.pc;
    assign bus.pc_plus4_e  = ex_r.pc_plus4;
    assign bus.op1_e       = ex_r.op1;
    assign bus.op2_e       = ex_r.op2;
    assign bus.rs1_e       = ex_r.rs1;
    assign bus.rs2_e       = ex_r.rs2;
    assign bus.rd_e        = ex_r.rd;
    assign bus.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: bypass, load-use bubble, hold/flush,
// asynchronous reset and counter saturation (counter narrowed to 4 bits).
module tb_decode_execute_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    decode_execute_stage_if #(.XLEN(32), .CTRL_W(16), .CNT_W(4)) bus ();

    decode_execute_stage #(.XLEN(32), .CTRL_W(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.valid_d = 1'b0;  bus.instr_d = 32'h0;  bus.pc_d = 32'h0;  bus.pc_plus4_d = 32'h0;
        bus.ctrl_d = 16'h0;  bus.reg_write_d = 1'b0;  bus.mem_read_d = 1'b0;
        bus.rd1_d = 32'h0;  bus.rd2_d = 32'h0;  bus.wb_we = 1'b0;  bus.wb_rd = 5'd0;
        bus.wb_data = 32'h0;  bus.hold_e = 1'b0;  bus.flush_e = 1'b0;

        #12;
        chk("reset_valid_e", bus.valid_e, 1'b0);
        chk("reset_cnt", bus.stall_cnt, 4'd0);
        chk("reset_op1_e", bus.op1_e, 32'h0);
        rst = 1'b0;
        step();

        // Bypass on rs1 from write-back
        bus.valid_d = 1'b1;  bus.instr_d = r_add(5'd3, 5'd1, 5'd2);
        bus.pc_d = 32'h100;  bus.pc_plus4_d = 32'h104;  bus.ctrl_d = 16'h5A5A;
        bus.reg_write_d = 1'b1;  bus.rd1_d = 32'h11;  bus.rd2_d = 32'h22;
        bus.wb_we = 1'b1;  bus.wb_rd = 5'd1;  bus.wb_data = 32'hABCD;
        #1;
        chk("rs1_d", bus.rs1_d, 5'd1);
        chk("rs2_d", bus.rs2_d, 5'd2);
        step();
        chk("byp_op1", bus.op1_e, 32'hABCD);
        chk("byp_op2", bus.op2_e, 32'h22);
        chk("byp_valid", bus.valid_e, 1'b1);
        chk("byp_rd", bus.rd_e, 5'd3);
        chk("byp_pc", bus.pc_e, 32'h100);
        chk("byp_pc4", bus.pc_plus4_e, 32'h104);
        chk("byp_ctrl", bus.ctrl_e, 16'h5A5A);
        chk("byp_rs", {bus.rs1_e, bus.rs2_e}, {5'd1, 5'd2});
        chk("byp_regw", bus.reg_write_e, 1'b1);

        // x0 never bypassed, even when wb_rd is 0
        bus.instr_d = r_add(5'd3, 5'd0, 5'd2);  bus.rd1_d = 32'h33;  bus.wb_rd = 5'd0;
        step();
        chk("x0_op1", bus.op1_e, 32'h33);
        chk("x0_op2", bus.op2_e, 32'h22);

        // Bypass on rs2
        bus.instr_d = r_add(5'd4, 5'd0, 5'd2);  bus.wb_rd = 5'd2;  bus.wb_data = 32'h77;
        step();
        chk("byp2_op1", bus.op1_e, 32'h33);
        chk("byp2_op2", bus.op2_e, 32'h77);

        // Load-use: lw x5 then add x6,x5,x7
        bus.wb_we = 1'b0;  bus.instr_d = i_lw(5'd5, 5'd1);  bus.mem_read_d = 1'b1;
        step();
        chk("lw_memrd_e", bus.mem_read_e, 1'b1);
        chk("lw_rd_e", bus.rd_e, 5'd5);
        bus.instr_d = r_add(5'd6, 5'd5, 5'd7);  bus.mem_read_d = 1'b0;  bus.pc_d = 32'h108;
        #1;
        chk("lu_stall", bus.stall_d, 1'b1);
        step();
        chk("lu_bubble_valid", bus.valid_e, 1'b0);
        chk("lu_bubble_pc", bus.pc_e, 32'h0);
        chk("lu_cnt", bus.stall_cnt, 4'd1);
        chk("lu_stall_clear", bus.stall_d, 1'b0);
        step();
        chk("lu_add_valid", bus.valid_e, 1'b1);
        chk("lu_add_regs", {bus.rs1_e, bus.rs2_e, bus.rd_e}, {5'd5, 5'd7, 5'd6});
        chk("lu_cnt2", bus.stall_cnt, 4'd1);

        // Hold for three cycles: execute keeps add x6
        bus.hold_e = 1'b1;  bus.instr_d = r_add(5'd8, 5'd1, 5'd2);  bus.pc_d = 32'h10C;
        #1;
        chk("hold_stall", bus.stall_d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_rd", bus.rd_e, 5'd6);
            chk("hold_pc", bus.pc_e, 32'h108);
        end
        chk("hold_cnt", bus.stall_cnt, 4'd4);

        // Flush together with hold gives a bubble
        bus.flush_e = 1'b1;
        step();
        chk("flush_valid", bus.valid_e, 1'b0);
        chk("flush_rd", bus.rd_e, 5'd0);
        chk("flush_pc", bus.pc_e, 32'h0);
        chk("flush_ctrl", bus.ctrl_e, 16'h0);
        chk("flush_regw", bus.reg_write_e, 1'b0);
        chk("flush_cnt", bus.stall_cnt, 4'd5);
        bus.flush_e = 1'b0;  bus.hold_e = 1'b0;

        // Load to x0 never stalls
        bus.instr_d = i_lw(5'd0, 5'd1);  bus.mem_read_d = 1'b1;
        step();
        chk("lx0_memrd", bus.mem_read_e, 1'b1);
        chk("lx0_rd", bus.rd_e, 5'd0);
        bus.instr_d = r_add(5'd9, 5'd0, 5'd0);  bus.mem_read_d = 1'b0;
        #1;
        chk("lx0_stall", bus.stall_d, 1'b0);
        step();
        chk("lx0_valid", bus.valid_e, 1'b1);
        chk("lx0_rd9", bus.rd_e, 5'd9);
        chk("lx0_cnt", bus.stall_cnt, 4'd5);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.valid_e, 1'b0);
        chk("arst_rd", bus.rd_e, 5'd0);
        chk("arst_pc4", bus.pc_plus4_e, 32'h0);
        chk("arst_cnt", bus.stall_cnt, 4'd0);
        chk("arst_stall", bus.stall_d, 1'b0);
        #1;
        rst = 1'b0;

        // Invalid decode still loads its fields
        bus.valid_d = 1'b0;  bus.pc_d = 32'h200;  bus.instr_d = r_add(5'd1, 5'd2, 5'd3);
        bus.rd1_d = 32'h44;
        step();
        chk("inv_valid", bus.valid_e, 1'b0);
        chk("inv_pc", bus.pc_e, 32'h200);
        chk("inv_op1", bus.op1_e, 32'h44);
        chk("inv_rd", bus.rd_e, 5'd1);

        // Saturation of the 4-bit counter
        bus.hold_e = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("sat_cnt15", bus.stall_cnt, 4'hF);
        for (int i = 0; i < 3; i++) step();
        chk("sat_nowrap", bus.stall_cnt, 4'hF);
        chk("sat_hold_pc", bus.pc_e, 32'h200);
        bus.hold_e = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
